// File: rtl/nn_counter_pkg.sv
// Shared types and defaults for the MAC step-counter slice.
// Mode encoding matches the controller's mode pin directly.
package nn_counter_pkg;

  typedef enum logic {
    CNT_STICKY = 1'b0,
    CNT_RELOAD = 1'b1
  } cnt_mode_e;

  localparam int DEFAULT_LEN = 9;

endpackage

// File: rtl/nn_step_counter_ch.sv
// One step-counter channel: count, terminal detect, done flag and reload pending bit.
// Next-state done/pend are exported so the top can form the aggregate on the same edge.
module nn_step_counter_ch
  import nn_counter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_mode,
  input  logic             i_ack,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_pend_clr,
  output logic [CNT_W-1:0] o_q,
  output logic             o_done,
  output logic             o_done_nxt,
  output logic             o_pend_set
);

  logic [CNT_W-1:0] r_q;
  logic             r_done;
  logic             r_pend;

  logic             w_reload;
  logic [CNT_W-1:0] w_last;
  logic             w_step;
  logic             w_term;

  assign w_reload = (i_mode == CNT_RELOAD);
  assign w_last   = i_len - CNT_W'(1);

  // A finished sticky channel ignores further strobes until cleared.
  assign w_step = i_ack && !(!w_reload && r_done);
  // >= rather than == so a shrunken length still terminates an advanced counter.
  assign w_term = w_step && (r_q >= w_last);

  assign o_done_nxt = w_reload ? w_term : (r_done | w_term);
  assign o_pend_set = w_reload && (r_pend | w_term);

  always_ff @(negedge i_clk) begin
    if (i_rst || i_clr) begin
      r_q    <= '0;
      r_done <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (w_term) begin
        r_q <= '0;
      end else if (w_step) begin
        r_q <= r_q + CNT_W'(1);
      end
      r_done <= o_done_nxt;
      r_pend <= o_pend_set && !i_pend_clr;
    end
  end

  assign o_q    = r_q;
  assign o_done = r_done;

endmodule

// File: rtl/nn_mac_step_counter.sv
// Multi-channel step counter gating MAC accumulation; shared length register and aggregate ack_mac.
// All state moves on the falling clock edge; outputs are registered one edge after the ack.
module nn_mac_step_counter
  import nn_counter_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int N_CH        = 4,
  parameter int DEFAULT_LEN = nn_counter_pkg::DEFAULT_LEN
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_mode,
  input  logic                  i_len_we,
  input  logic [CNT_W-1:0]      i_len,
  input  logic [N_CH-1:0]       i_ack,
  output logic [N_CH-1:0]       o_done,
  output logic                  o_ack_mac,
  output logic [N_CH*CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_len;
  logic             r_ack_mac;

  logic [N_CH-1:0]  w_done_nxt;
  logic [N_CH-1:0]  w_pend_set;
  logic             w_all_pend;
  logic             w_ack_mac_nxt;

  // Clear leaves the length alone and also masks a same-edge length write.
  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      r_len <= CNT_W'(DEFAULT_LEN);
    end else if (!i_clr && i_len_we) begin
      r_len <= (i_len == '0) ? CNT_W'(1) : i_len;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      nn_step_counter_ch #(
        .CNT_W (CNT_W)
      ) u_ch (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_clr),
        .i_mode     (i_mode),
        .i_ack      (i_ack[g]),
        .i_len      (r_len),
        .i_pend_clr (w_all_pend),
        .o_q        (o_cnt[g*CNT_W +: CNT_W]),
        .o_done     (o_done[g]),
        .o_done_nxt (w_done_nxt[g]),
        .o_pend_set (w_pend_set[g])
      );
    end
  endgenerate

  // Pend bits are only ever set in reload mode, so this is inert in sticky mode.
  assign w_all_pend    = &w_pend_set;
  assign w_ack_mac_nxt = (i_mode == CNT_RELOAD) ? w_all_pend : (&w_done_nxt);

  always_ff @(negedge i_clk) begin
    if (i_rst || i_clr) begin
      r_ack_mac <= 1'b0;
    end else begin
      r_ack_mac <= w_ack_mac_nxt;
    end
  end

  assign o_ack_mac = r_ack_mac;

endmodule

// File: tb/tb_nn_mac_step_counter.sv
// Bench for nn_mac_step_counter: directed scenarios plus random traffic against a per-edge reference.
module tb_nn_mac_step_counter;

  localparam int CNT_W = 8;
  localparam int N_CH  = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  clr = 1'b0;
  logic                  mode = 1'b0;
  logic                  len_we = 1'b0;
  logic [CNT_W-1:0]      len_i = '0;
  logic [N_CH-1:0]       ack = '0;
  logic [N_CH-1:0]       done;
  logic                  ack_mac;
  logic [N_CH*CNT_W-1:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int m_q[N_CH];
  bit m_done[N_CH];
  bit m_pend[N_CH];
  bit m_ack_mac;
  int m_len;

  always #5 clk = ~clk;

  nn_mac_step_counter #(.CNT_W(CNT_W), .N_CH(N_CH), .DEFAULT_LEN(9)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr     (clr),
    .i_mode    (mode),
    .i_len_we  (len_we),
    .i_len     (len_i),
    .i_ack     (ack),
    .o_done    (done),
    .o_ack_mac (ack_mac),
    .o_cnt     (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sampled edge of the specified behaviour.
  task automatic model_edge();
    bit term[N_CH];
    bit all_set;
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin m_q[i] = 0; m_done[i] = 0; m_pend[i] = 0; end
      m_ack_mac = 0;
      m_len = 9;
    end else if (clr) begin
      for (int i = 0; i < N_CH; i++) begin m_q[i] = 0; m_done[i] = 0; m_pend[i] = 0; end
      m_ack_mac = 0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        bit live;
        live = ack[i] && !(mode == 1'b0 && m_done[i]);
        term[i] = live && (m_q[i] + 1 >= m_len);
        if (term[i]) m_q[i] = 0;
        else if (live) m_q[i] = m_q[i] + 1;
      end
      all_set = 1;
      if (mode == 1'b0) begin
        for (int i = 0; i < N_CH; i++) begin
          m_done[i] = m_done[i] | term[i];
          all_set = all_set & m_done[i];
        end
        m_ack_mac = all_set;
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          m_done[i] = term[i];
          m_pend[i] = m_pend[i] | term[i];
          all_set = all_set & m_pend[i];
        end
        m_ack_mac = all_set;
        if (all_set) for (int i = 0; i < N_CH; i++) m_pend[i] = 0;
      end
      if (len_we) m_len = (len_i == 0) ? 1 : int'(len_i);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N_CH-1:0]       e_done;
    logic [N_CH*CNT_W-1:0] e_cnt;
    for (int i = 0; i < N_CH; i++) begin
      e_done[i] = m_done[i];
      e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_q[i]);
    end
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".ack_mac"}, 32'(ack_mac), 32'(m_ack_mac));
    chk({tag, ".cnt"}, cnt, e_cnt);
  endtask

  // Drive on posedge, let the negedge sample, check 1 time unit later.
  task automatic step(input string tag, input logic [N_CH-1:0] a,
                      input logic lwe = 1'b0, input logic [CNT_W-1:0] li = '0,
                      input logic c = 1'b0, input logic r = 1'b0);
    @(posedge clk);
    ack = a; len_we = lwe; len_i = li; clr = c; rst = r;
    @(negedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    // 1: reset defaults, default length 9
    step("rst", 4'h0, 1'b0, '0, 1'b0, 1'b1);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ackmac", 32'(ack_mac), 32'h0);
    chk("rst_cnt", cnt, 32'h0);
    for (int k = 1; k <= 9; k++) step("t1", 4'h1);
    chk("t1_done9", 32'(done), 32'h1);

    // 2: sticky aggregate with staggered channels, len 3
    step("t2clr", 4'h0, 1'b0, '0, 1'b1);
    step("t2len", 4'h0, 1'b1, 8'd3);
    for (int k = 0; k < 3; k++) step("t2a", 4'h1);
    for (int k = 0; k < 3; k++) step("t2b", 4'h2);
    for (int k = 0; k < 3; k++) step("t2c", 4'h4);
    for (int k = 0; k < 2; k++) step("t2d", 4'h8);
    chk("t2_premac", 32'(ack_mac), 32'h0);
    step("t2e", 4'h8);
    chk("t2_mac", 32'(ack_mac), 32'h1);
    step("t2x", 4'hF);
    step("t2x", 4'hF);
    chk("t2_hold_mac", 32'(ack_mac), 32'h1);
    chk("t2_hold_done", 32'(done), 32'hF);
    chk("t2_hold_cnt", cnt, 32'h0);

    // 3: reload, len 2
    mode = 1'b1;
    step("t3clr", 4'h0, 1'b0, '0, 1'b1);
    step("t3len", 4'h0, 1'b1, 8'd2);
    for (int k = 1; k <= 6; k++) begin
      step("t3a", 4'hF);
      chk("t3_done", 32'(done), (k % 2 == 0) ? 32'hF : 32'h0);
      chk("t3_mac", 32'(ack_mac), (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    step("t3clr2", 4'h0, 1'b0, '0, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      step("t3b", (e % 2 == 0) ? 4'hF : 4'h1);
      chk("t3_slow_mac", 32'(ack_mac), (e % 4 == 0) ? 32'h1 : 32'h0);
    end

    // 4: length shrink with simultaneous ack uses the old length
    mode = 1'b0;
    step("t4clr", 4'h0, 1'b0, '0, 1'b1);
    step("t4len", 4'h0, 1'b1, 8'd9);
    for (int k = 0; k < 6; k++) step("t4a", 4'h1);
    step("t4shrink", 4'h1, 1'b1, 8'd4);
    chk("t4_q7", 32'(cnt[7:0]), 32'd7);
    step("t4term", 4'h1);
    chk("t4_q0", 32'(cnt[7:0]), 32'd0);
    chk("t4_done", 32'(done[0]), 32'h1);

    // 5: priority and length retention across clr
    step("t5all", 4'hF, 1'b1, 8'd2, 1'b1, 1'b1);
    chk("t5_rst_cnt", cnt, 32'h0);
    step("t5len", 4'h0, 1'b1, 8'd5);
    for (int k = 0; k < 4; k++) step("t5a", 4'h1);
    step("t5clr", 4'h0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) step("t5b", 4'h1);
    chk("t5_not_done", 32'(done[0]), 32'h0);
    step("t5c", 4'h1);
    chk("t5_done5", 32'(done[0]), 32'h1);
    mode = 1'b1;
    step("t5clr2", 4'h0, 1'b1, 8'd0, 1'b1);
    step("t5len0", 4'h0, 1'b1, 8'd0);
    for (int k = 0; k < 3; k++) begin
      step("t5z", 4'h1);
      chk("t5_len0_done", 32'(done[0]), 32'h1);
    end

    // 6: reset mid-operation
    mode = 1'b0;
    step("t6rst", 4'h0, 1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) step("t6a", 4'h1);
    for (int k = 0; k < 4; k++) step("t6b", 4'h2);
    chk("t6_q4", 32'(cnt[15:8]), 32'd4);
    step("t6r", 4'h0, 1'b0, '0, 1'b0, 1'b1);
    chk("t6_cleared", cnt, 32'h0);
    step("t6idle", 4'h0);
    chk("t6_mac0", 32'(ack_mac), 32'h0);

    // Random traffic; mode changes only together with a clear.
    for (int c = 0; c < 600; c++) begin
      logic [N_CH-1:0] a;
      logic lwe;
      logic [CNT_W-1:0] li;
      logic cl;
      a   = N_CH'($urandom) & N_CH'($urandom | $urandom);
      lwe = ($urandom_range(0, 15) == 0);
      li  = CNT_W'($urandom_range(0, 6));
      cl  = 1'b0;
      if (c % 50 == 0) begin
        mode = 1'($urandom);
        cl = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        cl = 1'b1;
      end
      step("rnd", a, lwe, li, cl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
